// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 bus: an on-chip word RAM with configurable
// read latency, plus a switches/hex-display register mapped at a single I/O address.
module slc3_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          READ_LAT   = 1,
  parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_Data,
  output logic        Rd_Valid,
  output logic        Busy,
  output logic        Bus_Err
);

  localparam int       DEPTH    = 1 << DEPTH_LOG2;
  localparam bit [2:0] CNT_INIT = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR_HOLD} state_t;

  state_t                state_reg;
  logic [2:0]            wait_cnt_reg;
  logic [DEPTH_LOG2-1:0] rd_addr_reg;
  logic                  rd_io_reg;

  logic [15:0]           mem [DEPTH];
  logic                  is_io;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [15:0]           ram_rdata;

  assign is_io  = (ADDR == IO_ADDR);
  assign ram_we = !Reset && (state_reg == IDLE) && Mem_WE && !is_io;

  // One read port: the live address while idle, the captured one while waiting.
  assign ram_raddr = (state_reg == IDLE) ? ADDR[DEPTH_LOG2-1:0] : rd_addr_reg;
  assign ram_rdata = mem[ram_raddr];

  // RAM contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (ram_we)
      mem[ADDR[DEPTH_LOG2-1:0]] <= Data_from_CPU;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 3'd0;
      rd_addr_reg  <= '0;
      rd_io_reg    <= 1'b0;
      Data_to_CPU  <= 16'h0000;
      HEX_Data     <= 16'h0000;
      Rd_Valid     <= 1'b0;
      Busy         <= 1'b0;
      Bus_Err      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Mem_WE) begin
            if (is_io)
              HEX_Data <= Data_from_CPU;
            if (Mem_OE)
              Bus_Err <= 1'b1;
            state_reg <= WR_HOLD;
            Busy      <= 1'b1;
          end else if (Mem_OE) begin
            rd_addr_reg <= ADDR[DEPTH_LOG2-1:0];
            rd_io_reg   <= is_io;
            Busy        <= 1'b1;
            if (READ_LAT == 1) begin
              Data_to_CPU <= is_io ? Switches : ram_rdata;
              Rd_Valid    <= 1'b1;
              state_reg   <= RD_HOLD;
            end else begin
              wait_cnt_reg <= CNT_INIT;
              state_reg    <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          // Dropping OE before the data lands abandons the read silently.
          if (!Mem_OE) begin
            wait_cnt_reg <= 3'd0;
            state_reg    <= IDLE;
            Busy         <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
            if (wait_cnt_reg == 3'd1) begin
              Data_to_CPU <= rd_io_reg ? Switches : ram_rdata;
              Rd_Valid    <= 1'b1;
              state_reg   <= RD_HOLD;
            end
          end
        end

        RD_HOLD: begin
          if (!Mem_OE) begin
            Rd_Valid  <= 1'b0;
            state_reg <= IDLE;
            Busy      <= 1'b0;
          end
        end

        WR_HOLD: begin
          if (!Mem_WE) begin
            state_reg <= IDLE;
            Busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: vector table with a read-data scoreboard, plus hand
// sequences for long strobes, bus errors, reset mid-read and a 3-cycle latency instance.
module tb_slc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Mem_OE, Mem_WE, oe3, we3;
  logic [15:0] ADDR, Data_from_CPU, Switches;
  logic [15:0] Data_to_CPU, HEX_Data, data3, hex3;
  logic        Rd_Valid, Busy, Bus_Err, rv3, busy3, err3;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic        rv_prev = 1'b0;

  always #5 Clk = ~Clk;

  slc3_mem_responder #(.DEPTH_LOG2(10), .READ_LAT(1), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Switches(Switches),
    .HEX_Data(HEX_Data), .Rd_Valid(Rd_Valid), .Busy(Busy), .Bus_Err(Bus_Err)
  );

  slc3_mem_responder #(.DEPTH_LOG2(10), .READ_LAT(3), .IO_ADDR(16'hFFFF)) dut3 (
    .Clk(Clk), .Reset(Reset), .Mem_OE(oe3), .Mem_WE(we3), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(data3), .Switches(Switches),
    .HEX_Data(hex3), .Rd_Valid(rv3), .Busy(busy3), .Bus_Err(err3)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] sw;
    logic [15:0] exp;   // read data for reads, HEX_Data after the access for writes
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  // Scoreboard: every rising edge of Rd_Valid consumes one expected read value.
  always @(negedge Clk) begin
    if (Rd_Valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: Rd_Valid rose with data %h, no read expected", Data_to_CPU);
      end else
        check("sb_rd_data", Data_to_CPU, exp_q.pop_front());
    end
    rv_prev = Rd_Valid;
  end

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge Clk);
    ADDR = a; Data_from_CPU = d; Mem_WE = 1'b1;
    @(negedge Clk);
    check("wr_busy1", {15'd0, Busy}, 16'd1);
    @(negedge Clk);
    check("wr_busy2", {15'd0, Busy}, 16'd1);
    Mem_WE = 1'b0;
    @(negedge Clk);
    check("wr_busy_end", {15'd0, Busy}, 16'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
    @(negedge Clk);
    ADDR = a; Mem_OE = 1'b1;
    exp_q.push_back(exp);
    @(negedge Clk);
    check("rd_valid_2nd_cycle", {15'd0, Rd_Valid}, 16'd1);
    ADDR = a ^ 16'h0001;   // must be ignored while holding
    @(negedge Clk);
    check("rd_hold_stable", Data_to_CPU, exp);
    check("rd_busy", {15'd0, Busy}, 16'd1);
    Mem_OE = 1'b0;
    @(negedge Clk);
    check("rd_valid_fall", {15'd0, Rd_Valid}, 16'd0);
    check("rd_data_kept", Data_to_CPU, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h1234};
    tbl[2]  = '{1'b1, 16'h0007, 16'h0F0F, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 16'h0407, 16'h7777, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0007, 16'h0000, 16'h0000, 16'h7777};
    tbl[5]  = '{1'b0, 16'h0407, 16'h0000, 16'h0000, 16'h7777};
    tbl[6]  = '{1'b1, 16'h03FF, 16'hA5A5, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b1, 16'hFFFF, 16'h00C3, 16'h0000, 16'h00C3};
    tbl[8]  = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 16'hA5A5};
    tbl[9]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 16'hBEEF};
    tbl[10] = '{1'b1, 16'h0008, 16'h1111, 16'h0000, 16'h00C3};
    tbl[11] = '{1'b0, 16'h0008, 16'h0000, 16'h0000, 16'h1111};
    tbl[12] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1357, 16'h1357};

    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; oe3 = 1'b0; we3 = 1'b0;
    ADDR = 16'h0000; Data_from_CPU = 16'h0000; Switches = 16'h0000;
    repeat (3) @(negedge Clk);
    check("rst_data", Data_to_CPU, 16'h0000);
    check("rst_hex", HEX_Data, 16'h0000);
    check("rst_flags", {13'd0, Rd_Valid, Busy, Bus_Err}, 16'h0000);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      Switches = tbl[i].sw;
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data);
        check($sformatf("tbl%0d_hex", i), HEX_Data, tbl[i].exp);
      end else
        do_read(tbl[i].addr, tbl[i].exp);
    end
    check("no_bus_err", {15'd0, Bus_Err}, 16'd0);

    // WE held 4 edges while the data changes: only the first edge commits.
    @(negedge Clk);
    ADDR = 16'h0010; Data_from_CPU = 16'hAAAA; Mem_WE = 1'b1;
    @(negedge Clk);
    Data_from_CPU = 16'hBBBB;
    repeat (3) @(negedge Clk);
    Mem_WE = 1'b0;
    @(negedge Clk);
    do_read(16'h0010, 16'hAAAA);

    // OE and WE together: write wins, Bus_Err sticks.
    @(negedge Clk);
    ADDR = 16'h0020; Data_from_CPU = 16'h5555; Mem_OE = 1'b1; Mem_WE = 1'b1;
    @(negedge Clk);
    check("bus_err_set", {15'd0, Bus_Err}, 16'd1);
    @(negedge Clk);
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    repeat (10) @(negedge Clk);
    check("bus_err_sticky", {15'd0, Bus_Err}, 16'd1);
    check("bus_err_idle", {15'd0, Busy}, 16'd0);
    do_read(16'h0020, 16'h5555);

    // Reset while holding read data.
    @(negedge Clk);
    ADDR = 16'h0005; Mem_OE = 1'b1;
    exp_q.push_back(16'h1234);
    @(negedge Clk);
    check("pre_rst_valid", {15'd0, Rd_Valid}, 16'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_flags", {13'd0, Rd_Valid, Busy, Bus_Err}, 16'h0000);
    check("midrst_data", Data_to_CPU, 16'h0000);
    check("midrst_hex", HEX_Data, 16'h0000);
    Reset = 1'b0; Mem_OE = 1'b0;
    @(negedge Clk);
    do_read(16'h0005, 16'h1234);
    do_read(16'h0010, 16'hAAAA);

    // READ_LAT=3 instance.
    @(negedge Clk);
    ADDR = 16'h0030; Data_from_CPU = 16'h3333; we3 = 1'b1;
    repeat (2) @(negedge Clk);
    we3 = 1'b0;
    repeat (2) @(negedge Clk);
    ADDR = 16'h0030; oe3 = 1'b1;
    @(negedge Clk);
    check("lat3_edge1_valid", {14'd0, rv3, busy3}, 16'h0001);
    @(negedge Clk);
    check("lat3_edge2_valid", {15'd0, rv3}, 16'd0);
    @(negedge Clk);
    check("lat3_edge3_valid", {15'd0, rv3}, 16'd1);
    check("lat3_data", data3, 16'h3333);
    oe3 = 1'b0;
    @(negedge Clk);
    check("lat3_release", {14'd0, rv3, busy3}, 16'h0000);

    @(negedge Clk);
    ADDR = 16'h0031; oe3 = 1'b1;
    @(negedge Clk);
    check("abort_edge1", {15'd0, rv3}, 16'd0);
    @(negedge Clk);
    check("abort_edge2", {15'd0, rv3}, 16'd0);
    oe3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check($sformatf("abort_idle%0d", k), {14'd0, rv3, busy3}, 16'h0000);
    end
    check("abort_data_kept", data3, 16'h3333);

    Switches = 16'hCAFE;
    @(negedge Clk);
    ADDR = 16'hFFFF; oe3 = 1'b1;
    repeat (3) @(negedge Clk);
    check("lat3_io_valid", {15'd0, rv3}, 16'd1);
    check("lat3_io_data", data3, 16'hCAFE);
    oe3 = 1'b0;
    @(negedge Clk);

    check("sb_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
